// File: rtl/syncdown_timer.sv
// Loadable down-counter timer with one-cycle terminal-count pulse, sticky done
// flag, and selectable one-shot or auto-reload behaviour.
module syncdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload_en,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rv_q, rv_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rv_q    <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rv_q    <= rv_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rv_d    = rv_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (load) begin
            q_d     = load_val;
            rv_d    = load_val;
            state_d = RUN;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (en) begin
                        if (q_q == '0) begin
                            // Expiry is taken on zero, so the count never wraps to all-ones.
                            tc_d = 1'b1;
                            if (reload_en) begin
                                q_d = rv_q;
                            end else begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            q_d = q_q - 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (ack) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // busy is registered so it tracks the state that will be current next cycle.
        busy_d = (state_d == RUN);
    end

    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_syncdown_timer.sv
// Scoreboarded bench for syncdown_timer: directed scenarios followed by random
// stimulus, all checked against a behavioural timer model.
module tb_syncdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         reload_en = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    syncdown_timer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .en        (en),
        .reload_en (reload_en),
        .ack       (ack),
        .q         (q),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Behavioural model: a timer is either running (counting toward zero) or not;
    // "expired" is simply "not running with done still raised".
    int unsigned m_count = 0;
    int unsigned m_reload = 0;
    bit          m_running = 0;
    bit          m_done = 0;
    bit          m_tc = 0;

    task automatic model_step(input bit r, input bit ld, input int unsigned v,
                              input bit e, input bit rel, input bit a);
        m_tc = 0;
        if (r) begin
            m_count = 0; m_reload = 0; m_running = 0; m_done = 0;
        end else if (ld) begin
            m_count = v; m_reload = v; m_running = 1; m_done = 0;
        end else if (m_running && e) begin
            if (m_count == 0) begin
                m_tc = 1;
                if (rel) m_count = m_reload;
                else begin
                    m_running = 0;
                    m_done = 1;
                end
            end else begin
                m_count = m_count - 1;
            end
        end else if (!m_running && m_done && a) begin
            m_done = 0;
        end
    endtask

    task automatic step(input bit r, input bit ld, input int unsigned v,
                        input bit e, input bit rel, input bit a);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = W'(v); en = e; reload_en = rel; ack = a;
        model_step(r, ld, v, e, rel, a);
        x.q = W'(m_count); x.tc = m_tc; x.busy = m_running; x.done = m_done;
        exp_q.push_back(x);
    endtask

    // Monitor: every edge presents a registered output word; compare it with
    // the expectation queued when that edge's stimulus was issued.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests++;
                if (q !== x.q || tc !== x.tc || busy !== x.busy || done !== x.done) begin
                    errors++;
                    $display("FAIL cyc%0d outputs: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                             cycle, q, tc, busy, done, x.q, x.tc, x.busy, x.done);
                end else begin
                    $display("[TB] cyc%0d ok q=%0d tc=%b busy=%b done=%b", cycle, q, tc, busy, done);
                end
            end
        end
    end

    int tc_seen;

    initial begin
        // reset, then get into RUN with q=5 and reset mid-count
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 8, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);

        // one-shot from 3, then ack
        step(0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // auto-reload from 2: four tc pulses in twelve enabled cycles
        step(0, 1, 2, 0, 1, 0);
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 1, 0);
            @(posedge clk);
            #2;
            if (tc === 1'b1) tc_seen++;
        end
        tests++;
        if (tc_seen != 4) begin
            errors++;
            $display("FAIL autoreload_tc_count: got %0d pulses, want 4", tc_seen);
        end

        // enable gating from 4
        step(0, 1, 4, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, (i % 2) == 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // boundaries: zero and full-scale loads
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 15, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 1, 0, 0);

        // priority: load coinciding with expiry, and load together with ack
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 7, 1, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 6, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 15),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        rst = 0; load = 0; en = 0; ack = 0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/syncdown_timer.md
# syncdown_timer

Synchronous loadable down-counter timer: the counting-down counterpart to the team's free-running 4-bit up counter. It is loaded with a start value, decrements on each enabled clock, and signals expiry with a one-cycle terminal-count pulse plus a sticky done flag. The done flag stays set until acknowledged. It supports one-shot and auto-reload modes and is the timeout/interval source for control logic fed by the up counters.

## Interface
- WIDTH, 4, counter width in bits (legal range 2–16)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load  input  1  load load_val and start counting; highest priority after rst
- load_val  input  WIDTH  start/reload value, sampled only when load=1
- en  input  1  count enable; decrement occurs only when en=1 in RUN
- reload_en  input  1  1 = auto-reload at expiry, 0 = one-shot; sampled at the expiry cycle
- ack  input  1  clears done and returns EXPIRED to IDLE
- q  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  1 while state is RUN, registered
- done  output  1  sticky expiry flag, registered

## Operation
- Internal reload register rv[WIDTH-1:0] captures load_val on every accepted load.
- State machine: IDLE, RUN, EXPIRED.
- Reset (rst=1 at a clock edge) sets state=IDLE, q=0, rv=0, tc=0, busy=0, done=0. Reset overrides every other input, including mid-count.
- Any state with load=1: q<=load_val, rv<=load_val, state<=RUN, done<=0, tc<=0. Load wins over en and ack in the same cycle.
- IDLE, no load: q holds and tc=0. en and ack are ignored.
- RUN, en=0: q holds and tc=0.
- RUN, en=1, q!=0: q<=q-1 and tc<=0.
- RUN, en=1, q==0 (expiry):
  - tc<=1 for exactly one cycle.
  - If reload_en=1: q<=rv and state stays RUN; done is unaffected. The period is rv+1 enabled cycles.
  - If reload_en=0: q stays 0, state<=EXPIRED, done<=1.
- EXPIRED, no load: q holds 0. ack=1 sets done<=0 and state<=IDLE; ack=0 holds.
- busy is 1 exactly when the registered state is RUN.
- Width and arithmetic:
  - Subtraction is modulo 2^WIDTH, but q==0 always takes the expiry path, so the counter never underflows to all-ones.
  - A load_val of 0 is legal: q=0 in RUN, and the next enabled cycle expires.

## Timing
- All outputs change only on the rising edge of clk. There are no combinational input-to-output paths.
- Load latency: load at edge N gives q=load_val and busy=1 after edge N.
- Decrement: one count per clock edge with en=1 in RUN.
- From a load of value V with en held high:
  - q reaches 0 after V edges.
  - tc is high after edge V+1, for one cycle.
  - In one-shot mode, done=1 and busy=0 after that same edge V+1.
- Auto-reload with en held high gives one tc pulse every rv+1 cycles. q shows rv in the cycle tc is high.
- ack at edge M: done=0 after edge M.
- ack while done=0 has no effect.
- Simultaneous load and expiry: the load wins, tc stays 0 and done stays 0.
- en deasserted at q==0: expiry is postponed until en returns. tc never fires without en.

## Test plan
- Reset and idle:
  - Assert rst for 2 cycles mid-count (q=5, RUN) -> q=0, tc=0, busy=0, done=0 next cycle.
  - Then en=1 with no load -> q stays 0.
- One-shot (WIDTH=4):
  - load_val=3, reload_en=0, en held 1 -> q sequence 3,2,1,0,0.
  - tc=1 in exactly one cycle, simultaneous with done rising to 1 and busy falling to 0.
  - ack -> done=0, state IDLE.
- Auto-reload:
  - load_val=2, reload_en=1, en=1 for 12 cycles -> q sequence 2,1,0,2,1,0,...
  - tc pulses exactly 4 times, 3 cycles apart; done stays 0.
- Enable gating:
  - load_val=4, en toggled 1,0,1,0,... -> q decrements only on en=1 cycles.
  - Expiry occurs after the 5th enabled cycle.
- Boundaries:
  - load_val=0 with en=1 -> tc one cycle after the next edge, done=1.
  - load_val=15 -> 16 enabled cycles to expiry, with no underflow to 15 afterwards.
- Priority:
  - load=1 (val=7) in the same cycle as expiry -> q=7, tc=0, done=0.
  - load=1 together with ack in EXPIRED -> RUN, q=load_val, done=0.
